// File: rtl/oclib_pulse_shaper.sv
// Turns single-cycle event strobes into fixed-width output pulses with a guaranteed
// minimum low gap between them; events arriving mid-pulse queue in a saturating counter.
module oclib_pulse_shaper #(
  parameter int unsigned MinHighCycles = 100,
  parameter int unsigned MinLowCycles  = 100,
  parameter int unsigned MaxPending    = 15,
  parameter int unsigned SyncCycles    = 3,
  parameter bit          ResetSync     = 1'b0,
  parameter int unsigned ResetPipeline = 0,
  localparam int unsigned PendingW     = $clog2(MaxPending + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in,
  output logic                out,
  output logic                busy,
  output logic [PendingW-1:0] pending,
  output logic                overflow
);

  localparam int unsigned TimerMax = (MinHighCycles > MinLowCycles) ? MinHighCycles : MinLowCycles;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  // Reset conditioning: optional synchronizer followed by optional pipeline stages.
  logic reset_cond;
  logic resetSync;

  if (ResetSync) begin : g_sync
    logic [SyncCycles-1:0] sync_q;
    always_ff @(posedge clock) begin
      sync_q <= SyncCycles'({sync_q, reset});
    end
    assign reset_cond = sync_q[SyncCycles-1];
  end else begin : g_nosync
    assign reset_cond = reset;
  end

  if (ResetPipeline > 0) begin : g_pipe
    logic [ResetPipeline-1:0] pipe_q;
    always_ff @(posedge clock) begin
      pipe_q <= ResetPipeline'({pipe_q, reset_cond});
    end
    assign resetSync = pipe_q[ResetPipeline-1];
  end else begin : g_nopipe
    assign resetSync = reset_cond;
  end

  state_e            state;
  logic [TimerW-1:0] timer;
  logic              avail;
  logic              high_done;
  logic              low_done;
  logic              consume;

  assign avail     = (pending != '0) || in;
  assign high_done = (timer == TimerW'(MinHighCycles));
  assign low_done  = (timer == TimerW'(MinLowCycles));
  // An event is taken when idle, or exactly when the minimum low gap has elapsed.
  assign consume   = avail && ((state == StIdle) || ((state == StLow) && low_done));

  // Pulse sequencer
  always_ff @(posedge clock) begin
    if (resetSync) begin
      state <= StIdle;
      timer <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (avail) begin
            state <= StHigh;
            timer <= TimerW'(1);
            out   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        StHigh: begin
          if (high_done) begin
            state <= StLow;
            timer <= TimerW'(1);
            out   <= 1'b0;
          end else begin
            timer <= timer + TimerW'(1);
          end
        end
        StLow: begin
          if (low_done) begin
            if (avail) begin
              state <= StHigh;
              timer <= TimerW'(1);
              out   <= 1'b1;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + TimerW'(1);
          end
        end
        default: begin
          state <= StIdle;
          timer <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Event queue: a strobe consumed in its own cycle never enters the queue.
  always_ff @(posedge clock) begin
    if (resetSync) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (in && !consume) begin
      if (pending < PendingW'(MaxPending)) begin
        pending <= pending + PendingW'(1);
      end else begin
        overflow <= 1'b1;
      end
    end else if (!in && consume) begin
      pending <= pending - PendingW'(1);
    end
  end

endmodule

// File: tb/tb_oclib_pulse_shaper.sv
// Directed and random stimulus for oclib_pulse_shaper, checked against a launch-time
// model: a pulse may start at an edge only if H+L edges have passed since the previous start.
module tb_oclib_pulse_shaper;

  localparam int unsigned H  = 3;
  localparam int unsigned L  = 2;
  localparam int unsigned MP = 2;
  localparam int unsigned PW = $clog2(MP + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          in;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  always #5 clock = ~clock;

  oclib_pulse_shaper #(
    .MinHighCycles(H),
    .MinLowCycles (L),
    .MaxPending   (MP),
    .SyncCycles   (3),
    .ResetSync    (1'b0),
    .ResetPipeline(0)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in),
    .out     (out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;
  int   last_launch = -1000;
  int   queue_cnt = 0;
  bit   ovf_m = 1'b0;
  int   pulses = 0;
  logic prev_out = 1'b0;
  int   p0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare.
  task automatic step(input logic i, input logic r);
    bit launch;
    in    = i;
    reset = r;
    @(posedge clock);
    if (r) begin
      last_launch = -1000;
      queue_cnt   = 0;
      ovf_m       = 1'b0;
    end else begin
      launch = ((queue_cnt > 0) || i) && ((edge_n - last_launch) >= int'(H + L));
      if (launch) last_launch = edge_n;
      if (i && !launch) begin
        if (queue_cnt < int'(MP)) queue_cnt++;
        else ovf_m = 1'b1;
      end else if (!i && launch) begin
        queue_cnt--;
      end
    end
    #1;
    check("out",      32'(out),      32'((edge_n - last_launch) < int'(H)));
    check("busy",     32'(busy),     32'((edge_n - last_launch) < int'(H + L)));
    check("pending",  32'(pending),  32'(queue_cnt));
    check("overflow", 32'(overflow), 32'(ovf_m));
    if (out === 1'b1 && prev_out === 1'b0) pulses++;
    prev_out = out;
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in    = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(2);

    // Single strobe from idle
    step(1'b1, 1'b0);
    idle(8);

    // Three back-to-back strobes
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    idle(16);

    // Four strobes: queue saturates and one event is dropped
    p0 = pulses;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    idle(16);
    check("pulses_after_saturation", 32'(pulses - p0), 32'd3);
    check("overflow_sticky_after_drain", 32'(overflow), 32'd1);
    step(1'b0, 1'b1);
    idle(2);

    // Strobe on the last low cycle relaunches without queuing
    step(1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0);
    idle(10);

    // Reset mid-pulse with one event queued, then a fresh strobe
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("reset_clears_out", 32'(out), 32'd0);
    check("reset_clears_pending", 32'(pending), 32'd0);
    step(1'b0, 1'b0);
    p0 = pulses;
    step(1'b1, 1'b0);
    idle(8);
    check("pulse_after_reset", 32'(pulses - p0), 32'd1);

    // Continuous strobing: strict 3-high/2-low cadence, queue pinned full
    p0 = pulses;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
    check("continuous_pulses", 32'(pulses - p0), 32'd4);
    check("continuous_overflow", 32'(overflow), 32'd1);
    idle(16);
    step(1'b0, 1'b1);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 99) == 0));
    end
    idle(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
